// File: rtl/lsl_pkg.sv
// Shared constants and types for the logical-shift-left ALU slice.
// The optional overflow flag is enabled by defining LSL_OVF_FLAG_EN.
package lsl_pkg;

    localparam int LSL_DATA_W  = 32;
    localparam int LSL_SHAMT_W = 4;

    // Flag vector bit positions, ordered {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flag_t;

endpackage

// File: rtl/lsl_unit_if.sv
// Request/response bundle between the execute stage and the shift slice.
// Handshake: in_valid qualifies In1/In2/Flag/S for one cycle; out_valid is a
// one-cycle pulse qualifying Result/New_Flag. There is no ready: the slice
// accepts one operation per cycle unconditionally.
interface lsl_unit_if
    import lsl_pkg::*;
#(
    parameter int DATA_W  = LSL_DATA_W,
    parameter int SHAMT_W = LSL_SHAMT_W
);

    logic               in_valid;
    logic [DATA_W-1:0]  In1;
    logic [SHAMT_W-1:0] In2;
    flag_t              Flag;
    logic               S;
    logic [DATA_W-1:0]  Result;
    flag_t              New_Flag;
    logic               out_valid;

    modport master (
        output in_valid, In1, In2, Flag, S,
        input  Result, New_Flag, out_valid
    );

    modport slave (
        input  in_valid, In1, In2, Flag, S,
        output Result, New_Flag, out_valid
    );

endinterface

// File: rtl/lsl_core.sv
// Combinational shift-left datapath: barrel shift, carry-out select and N/Z/C/V.
// LSL_OVF_FLAG_EN selects a computed signed-overflow V instead of passing V through.
module lsl_core
    import lsl_pkg::*;
#(
    parameter int DATA_W  = LSL_DATA_W,
    parameter int SHAMT_W = LSL_SHAMT_W
) (
    input  logic [DATA_W-1:0]  in1,
    input  logic [SHAMT_W-1:0] in2,
    input  flag_t              flag,
    input  logic               s,
    output logic [DATA_W-1:0]  result,
    output flag_t              new_flag
);

    logic [31:0]       sh;
    logic [DATA_W:0]   wide;
    logic              carry;
    logic              ovf;

    assign sh = 32'(in2);

    // Bit DATA_W of the one-bit-extended shift is exactly the last bit shifted
    // out for 1..DATA_W, and zero for larger amounts.
    always_comb begin
        wide   = {1'b0, in1} << sh;
        result = wide[DATA_W-1:0];
        carry  = (sh == 0) ? flag[FLAG_C] : wide[DATA_W];
    end

`ifdef LSL_OVF_FLAG_EN
    logic [2*DATA_W-1:0] wide_s;

    // Overflow when the sign-extended product no longer fits: every bit from
    // the new sign upward must still equal the original sign.
    always_comb begin
        wide_s = {{DATA_W{in1[DATA_W-1]}}, in1} << sh;
        if (sh >= 32'(DATA_W)) begin
            ovf = |in1;
        end else begin
            ovf = (wide_s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){in1[DATA_W-1]}});
        end
    end
`else
    assign ovf = flag[FLAG_V];
`endif

    always_comb begin
        new_flag = flag;
        if (s) begin
            new_flag[FLAG_N] = result[DATA_W-1];
            new_flag[FLAG_Z] = (result == '0);
            new_flag[FLAG_C] = carry;
            new_flag[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/lsl_unit.sv
// Registered logical-shift-left slice: one-cycle latency, outputs hold when idle.
// Build option LSL_OVF_FLAG_EN enables the computed overflow flag in lsl_core.
module lsl_unit
    import lsl_pkg::*;
#(
    parameter int DATA_W  = LSL_DATA_W,
    parameter int SHAMT_W = LSL_SHAMT_W
) (
    input  logic       clk,
    input  logic       rst,
    lsl_unit_if.slave  bus
);

    logic [DATA_W-1:0] core_result;
    flag_t             core_flag;

    logic [DATA_W-1:0] result_q;
    flag_t             flag_q;
    logic              valid_q;

    lsl_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .in1      (bus.In1),
        .in2      (bus.In2),
        .flag     (bus.Flag),
        .s        (bus.S),
        .result   (core_result),
        .new_flag (core_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flag_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= core_result;
                flag_q   <= core_flag;
            end
        end
    end

    assign bus.Result    = result_q;
    assign bus.New_Flag  = flag_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_lsl_unit.sv
// Directed bench for lsl_unit: vector table applied back-to-back, then
// hand-written idle-hold and reset-priority sequences.
module tb_lsl_unit;

    localparam int DW = 32;
    localparam int SW = 4;

    logic clk;
    logic rst;

    lsl_unit_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();

    lsl_unit #(.DATA_W(DW), .SHAMT_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] in1;
        logic [SW-1:0] in2;
        logic [3:0]    flag;
        logic          s;
        logic [DW-1:0] exp_result;
        logic [3:0]    exp_flag;   // V passed through
        logic          exp_v_ovf;  // V with computed overflow
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int total;
    int bad;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] expected_flag(input vec_t v);
        logic [3:0] f;
        f = v.exp_flag;
`ifdef LSL_OVF_FLAG_EN
        if (v.s) f[0] = v.exp_v_ovf;
`endif
        return f;
    endfunction

    logic [DW-1:0] last_result;
    logic [3:0]    last_flag;

    initial begin
        total = 0;
        bad   = 0;

        //          in1           in2    flag     s     result        flag     v_ovf
        vecs[0]  = '{32'd3,        4'd1,  4'b0000, 1'b1, 32'd6,        4'b0000, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 4'd9,  4'b0000, 1'b1, 32'hFFFFFE00, 4'b1010, 1'b0};
        vecs[2]  = '{32'hFFFFFFFA, 4'd4,  4'b0101, 1'b0, 32'hFFFFFFA0, 4'b0101, 1'b1};
        vecs[3]  = '{32'h80000000, 4'd1,  4'b0000, 1'b1, 32'h00000000, 4'b0110, 1'b1};
        vecs[4]  = '{32'd10,       4'd10, 4'b0000, 1'b1, 32'h00002800, 4'b0000, 1'b0};
        vecs[5]  = '{32'd5,        4'd0,  4'b0010, 1'b1, 32'd5,        4'b0010, 1'b0};
        vecs[6]  = '{32'h40000000, 4'd1,  4'b0000, 1'b1, 32'h80000000, 4'b1000, 1'b1};
        vecs[7]  = '{32'd1,        4'd15, 4'b0001, 1'b1, 32'h00008000, 4'b0001, 1'b0};
        vecs[8]  = '{32'd0,        4'd3,  4'b1111, 1'b1, 32'd0,        4'b0101, 1'b0};
        vecs[9]  = '{32'h12345678, 4'd4,  4'b0000, 1'b1, 32'h23456780, 4'b0010, 1'b1};
        vecs[10] = '{32'd0,        4'd0,  4'b1010, 1'b0, 32'd0,        4'b1010, 1'b0};
        vecs[11] = '{32'h00020000, 4'd15, 4'b0000, 1'b1, 32'h00000000, 4'b0110, 1'b1};
        vecs[12] = '{32'h00010000, 4'd15, 4'b0000, 1'b1, 32'h80000000, 4'b1000, 1'b1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.In1      = '0;
        bus.In2      = '0;
        bus.Flag     = '0;
        bus.S        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_result", bus.Result, 32'd0);
        check("reset_flag", 32'(bus.New_Flag), 32'd0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);

        // Table: one vector per cycle with in_valid held high throughout
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.In1      = vecs[i].in1;
            bus.In2      = vecs[i].in2;
            bus.Flag     = vecs[i].flag;
            bus.S        = vecs[i].s;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_result", i), bus.Result, vecs[i].exp_result);
            check($sformatf("v%0d_flag", i), 32'(bus.New_Flag), 32'(expected_flag(vecs[i])));
            check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end

        // Idle: outputs hold the last vector, out_valid drops after one edge
        last_result  = vecs[NV-1].exp_result;
        last_flag    = expected_flag(vecs[NV-1]);
        bus.in_valid = 1'b0;
        bus.In1      = 32'hDEADBEEF;
        bus.In2      = 4'd7;
        bus.Flag     = 4'b1111;
        bus.S        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle%0d_valid", k), 32'(bus.out_valid), 32'd0);
            check($sformatf("idle%0d_result", k), bus.Result, last_result);
            check($sformatf("idle%0d_flag", k), 32'(bus.New_Flag), 32'(last_flag));
        end

        // Reset wins over a simultaneous valid input
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.In1      = 32'hFFFFFFFF;
        bus.In2      = 4'd1;
        bus.Flag     = 4'b1111;
        bus.S        = 1'b1;
        @(posedge clk);
        #1;
        check("rstv_result", bus.Result, 32'd0);
        check("rstv_flag", 32'(bus.New_Flag), 32'd0);
        check("rstv_valid", 32'(bus.out_valid), 32'd0);

        // Single pulse after reset release
        @(negedge clk);
        rst = 1'b0;
        bus.In1  = 32'd3;
        bus.In2  = 4'd1;
        bus.Flag = 4'b0000;
        bus.S    = 1'b1;
        @(posedge clk);
        #1;
        check("post_result", bus.Result, 32'd6);
        check("post_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_end_valid", 32'(bus.out_valid), 32'd0);
        check("pulse_end_result", bus.Result, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsl_unit.md
Name: lsl_unit

Overview:
- Registered 32-bit logical-shift-left ALU slice with ARM-style condition flags.
- Flag vector order is [3]=N, [2]=Z, [1]=C, [0]=V.
- Used by the ALU execute stage: it takes an operand, a shift amount, the current flags and a set-flags bit (S).
- It returns the shifted result and the updated flags one clock later.

Parameters:
- SHAMT_W, 4, width of the shift-amount port In2. The shift amount is always interpreted as unsigned, 0..2^SHAMT_W-1.
- DATA_W, 32, operand and result width. Only 32 is verified.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- In1  input  DATA_W  operand to shift.
- In2  input  SHAMT_W  shift amount, unsigned.
- Flag  input  4  current flags {N,Z,C,V}.
- S  input  1  1 = update flags; 0 = pass Flag through unchanged.
- Result  output  DATA_W  registered In1 << In2.
- New_Flag  output  4  registered updated flags.
- out_valid  output  1  Result/New_Flag valid; one-cycle pulse.

Behaviour:
- Reset: clk and rst form one clock domain. Reset is synchronous and active-high. On a rising clk edge with rst=1, Result=0, New_Flag=4'b0000 and out_valid=0. This takes priority over in_valid.
- Latency: exactly 1 cycle. The edge that samples in_valid=1 loads Result/New_Flag and sets out_valid=1. The next edge without in_valid clears out_valid.
- Result and New_Flag hold their last value while in_valid=0. Back-to-back inputs give back-to-back outputs. There is no backpressure.
- Shift: sh = unsigned In2. Result = In1 << sh, zero-filled, truncated to DATA_W. If sh >= DATA_W (possible only when SHAMT_W > 5), Result = 0.
- Carry (last bit shifted out):
  - sh == 0: carry = Flag[1].
  - 1 <= sh <= DATA_W: carry = In1[DATA_W - sh].
  - sh > DATA_W: carry = 0.
- Flags when S=1: N = Result[DATA_W-1]; Z = (Result == 0); C = carry; V = Flag[0] (unchanged).
- Flags when S=0: New_Flag = Flag exactly. Result is still computed.
- The shift is combinational, feeding the output register. There is no multi-cycle state and no FSM.

Optional Feature:
- Macro: LSL_OVF_FLAG_EN.
- Defined, with S=1: V = 1 if any bit shifted out, or the new sign bit, differs from In1[DATA_W-1] (signed overflow of In1 * 2^sh). sh == 0 gives V=0.
- Not defined: V = Flag[0] as above.
- With S=0, Flag passes through in both builds.

Decomposition:
- Package lsl_pkg holds:
  - DATA_W default;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - a typedef for the 4-bit flag vector.
- Sub-module lsl_core is purely combinational: barrel shifter, carry select, N/Z/C/V compute.
- lsl_unit wraps lsl_core with the valid and output registers.

Test Plan:
- In1=3, In2=1, Flag=0000, S=1 -> next cycle Result=6, New_Flag=0000, out_valid=1.
- In1=32'hFFFFFFFF, In2=9, Flag=0000, S=1 -> Result=32'hFFFFFE00, New_Flag=1010 (N=1, C=In1[23]=1).
- In1=32'hFFFFFFFA (-6), In2=4, Flag=0101, S=0 -> Result=32'hFFFFFFA0, New_Flag=0101 (pass-through).
- In1=32'h80000000, In2=1, Flag=0000, S=1 -> Result=0, New_Flag=0110 (Z=1, C=1). Also In1=10, In2=10 (unsigned) -> Result=32'h2800, flags 0000.
- In1=5, In2=0, Flag=0010, S=1 -> Result=5, New_Flag=0010 (C preserved on zero shift).
- rst=1 asserted the same cycle as in_valid=1 -> Result=0, New_Flag=0, out_valid=0. With in_valid low for several cycles -> outputs hold and out_valid=0. With LSL_OVF_FLAG_EN: In1=32'h40000000, In2=1, S=1 -> V=1, N=1.
